// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing constants for the integer register file and its pending-write scoreboard.
package regfile_scoreboard_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int WORD_WIDTH     = 32;
    localparam int PEND_WIDTH     = 2;
    localparam int NREG           = 2 ** REG_ADDR_WIDTH;

    // Largest value a pending counter can hold before issue must be held off.
    function automatic logic [PEND_WIDTH-1:0] pend_max();
        return '1;
    endfunction

endpackage

// File: rtl/regfile_sb_pend.sv
// One pending-write counter: counts issued-but-not-retired writes to a single register.
module regfile_sb_pend #(
    parameter int PEND_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              uflow_o
);

    logic [PEND_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        uflow_o = dec_i && (cnt_q == '0);
        // issue and retire on the same edge cancel; a retire with nothing pending saturates at 0
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + PEND_W'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with two bypassed read ports and a per-register pending-write
// scoreboard that holds decode off until its sources and destination slot are available.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int WORD_W = WORD_WIDTH,
    parameter int PEND_W = PEND_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic              rs1_ren_i,
    input  logic              rs2_ren_i,
    output logic [WORD_W-1:0] rs1_data_o,
    output logic [WORD_W-1:0] rs2_data_o,
    input  logic              issue_valid_i,
    input  logic              issue_rd_wen_i,
    input  logic [ADDR_W-1:0] issue_rd_addr_i,
    output logic              stall_o,
    input  logic              wb_rd_wen_i,
    input  logic [ADDR_W-1:0] wb_rd_addr_i,
    input  logic [WORD_W-1:0] wb_data_i,
    output logic              sb_err_o
);

    localparam int                 NR   = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0]  PMAX = '1;

    logic [WORD_W-1:0]            regs_q [NR];
    logic [NR-1:0][PEND_W-1:0]    pend;
    logic [NR-1:1]                inc, dec, uflow;
    logic                         sb_err_q, sb_err_d;

    logic [1:0][ADDR_W-1:0]       rs_addr;
    logic [1:0]                   rs_ren;
    logic [1:0][WORD_W-1:0]       rs_data;
    logic [1:0]                   wb_hit, haz;
    logic                         rd_full, acc;

    assign rs_addr = {rs2_addr_i, rs1_addr_i};
    assign rs_ren  = {rs2_ren_i, rs1_ren_i};

    // Architectural state; x0 is never written so it stays at its reset value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NR; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wb_rd_wen_i && (wb_rd_addr_i != '0)) begin
            regs_q[wb_rd_addr_i] <= wb_data_i;
        end
    end

    // A source whose single outstanding write retires this cycle is served by the bypass.
    always_comb begin
        rs_data = '0;
        wb_hit  = '0;
        haz     = '0;
        for (int p = 0; p < 2; p++) begin
            wb_hit[p] = wb_rd_wen_i && (wb_rd_addr_i == rs_addr[p]) && (rs_addr[p] != '0);
            if (rs_addr[p] == '0) begin
                rs_data[p] = '0;
            end else if (wb_hit[p]) begin
                rs_data[p] = wb_data_i;
            end else begin
                rs_data[p] = regs_q[rs_addr[p]];
            end
            haz[p] = rs_ren[p] && (rs_addr[p] != '0) &&
                     (pend[rs_addr[p]] > PEND_W'(wb_hit[p]));
        end
    end

    assign rs1_data_o = rs_data[0];
    assign rs2_data_o = rs_data[1];

    always_comb begin
        rd_full = issue_rd_wen_i && (issue_rd_addr_i != '0) && (pend[issue_rd_addr_i] == PMAX);
        stall_o = issue_valid_i && (haz[0] || haz[1] || rd_full);
        acc     = issue_valid_i && !stall_o && issue_rd_wen_i && (issue_rd_addr_i != '0);
    end

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NR; r++) begin
            inc[r] = acc && (issue_rd_addr_i == ADDR_W'(r));
            dec[r] = wb_rd_wen_i && (wb_rd_addr_i == ADDR_W'(r));
        end
    end

    assign pend[0] = '0;

    for (genvar r = 1; r < NR; r++) begin : g_pend
        regfile_sb_pend #(
            .PEND_W (PEND_W)
        ) u_pend (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .inc_i   (inc[r]),
            .dec_i   (dec[r]),
            .cnt_o   (pend[r]),
            .uflow_o (uflow[r])
        );
    end

    assign sb_err_d = sb_err_q | (|uflow);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err_o = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus random stimulus against a behavioural array model of the register file.
module tb_regfile_scoreboard;

    localparam int AW = 5;
    localparam int WW = 32;
    localparam int NR = 32;
    localparam int PMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs1_addr, rs2_addr, issue_rd_addr, wb_rd_addr;
    logic          rs1_ren, rs2_ren, issue_valid, issue_rd_wen, wb_rd_wen;
    logic [WW-1:0] wb_data, rs1_data, rs2_data;
    logic          stall, sb_err;

    int total = 0;
    int bad   = 0;

    logic [WW-1:0] m_regs [NR];
    int            m_pend [NR];
    bit            m_err;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .rs1_addr_i      (rs1_addr),
        .rs2_addr_i      (rs2_addr),
        .rs1_ren_i       (rs1_ren),
        .rs2_ren_i       (rs2_ren),
        .rs1_data_o      (rs1_data),
        .rs2_data_o      (rs2_data),
        .issue_valid_i   (issue_valid),
        .issue_rd_wen_i  (issue_rd_wen),
        .issue_rd_addr_i (issue_rd_addr),
        .stall_o         (stall),
        .wb_rd_wen_i     (wb_rd_wen),
        .wb_rd_addr_i    (wb_rd_addr),
        .wb_data_i       (wb_data),
        .sb_err_o        (sb_err)
    );

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_rd_wen && wb_rd_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_haz(input logic [AW-1:0] a, input logic ren);
        int need;
        need = (wb_rd_wen && wb_rd_addr == a && a != 0) ? 1 : 0;
        return ren && a != 0 && m_pend[a] > need;
    endfunction

    function automatic bit m_stall();
        bit full;
        full = issue_rd_wen && issue_rd_addr != 0 && m_pend[issue_rd_addr] == PMAX;
        return issue_valid && (m_haz(rs1_addr, rs1_ren) || m_haz(rs2_addr, rs2_ren) || full);
    endfunction

    task automatic m_reset();
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        m_err = 0;
    endtask

    task automatic idle();
        rs1_addr = '0; rs2_addr = '0; rs1_ren = 0; rs2_ren = 0;
        issue_valid = 0; issue_rd_wen = 0; issue_rd_addr = '0;
        wb_rd_wen = 0; wb_rd_addr = '0; wb_data = '0;
    endtask

    // Inputs are already driven (at a negedge); check, clock once, advance model, return at negedge.
    task automatic step(input string tag);
        bit st, acc;
        int ia, wa;
        #1;
        st = m_stall();
        chk({tag, ".rs1"}, rs1_data, m_read(rs1_addr));
        chk({tag, ".rs2"}, rs2_data, m_read(rs2_addr));
        chk({tag, ".stall"}, {31'b0, stall}, {31'b0, st});
        chk({tag, ".err"}, {31'b0, sb_err}, {31'b0, m_err});
        acc = issue_valid && !st && issue_rd_wen && issue_rd_addr != 0;
        ia = int'(issue_rd_addr);
        wa = int'(wb_rd_addr);
        @(posedge clk);
        if (wb_rd_wen && wa != 0) begin
            m_regs[wa] = wb_data;
            if (m_pend[wa] == 0) m_err = 1;
            if (!(acc && ia == wa) && m_pend[wa] > 0) m_pend[wa]--;
        end
        if (acc && !(wb_rd_wen && wa == ia)) m_pend[ia]++;
        @(negedge clk);
    endtask

    initial begin
        int pick;
        idle();
        m_reset();
        rst_n = 0;
        rs1_addr = 5;
        #1;
        chk("rst.rs1", rs1_data, 32'h0);
        chk("rst.rs2", rs2_data, 32'h0);
        chk("rst.stall", {31'b0, stall}, 32'h0);
        chk("rst.err", {31'b0, sb_err}, 32'h0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // plain write and x0 write
        idle(); wb_rd_wen = 1; wb_rd_addr = 5; wb_data = 32'hDEADBEEF; step("wr5");
        idle(); rs1_addr = 5; wb_rd_wen = 1; wb_rd_addr = 0; wb_data = 32'h1234; #1;
        chk("rd5", rs1_data, 32'hDEADBEEF);
        chk("rd0", rs2_data, 32'h0);
        step("wr0");

        // same-cycle bypass
        idle(); rs2_addr = 7; wb_rd_wen = 1; wb_rd_addr = 7; wb_data = 32'hA5A5A5A5; #1;
        chk("byp7", rs2_data, 32'hA5A5A5A5);
        step("byp");

        // RAW on x3
        idle(); issue_valid = 1; issue_rd_wen = 1; issue_rd_addr = 3; step("iss3");
        idle(); issue_valid = 1; rs1_addr = 3; rs1_ren = 1; #1;
        chk("raw.stall", {31'b0, stall}, 32'h1);
        step("raw1");
        step("raw2");
        wb_rd_wen = 1; wb_rd_addr = 3; wb_data = 32'h0BADF00D; #1;
        chk("raw.go", {31'b0, stall}, 32'h0);
        chk("raw.byp", rs1_data, 32'h0BADF00D);
        step("raw3");

        // saturation on x9
        idle(); issue_valid = 1; issue_rd_wen = 1; issue_rd_addr = 9;
        step("sat1"); step("sat2"); step("sat3");
        #1;
        chk("sat.stall", {31'b0, stall}, 32'h1);
        step("sat4");
        idle(); wb_rd_wen = 1; wb_rd_addr = 9; wb_data = 32'h99; step("sat.wb");
        idle(); issue_valid = 1; issue_rd_wen = 1; issue_rd_addr = 9; #1;
        chk("sat.acc", {31'b0, stall}, 32'h0);
        step("sat5");

        // underflow on x4
        idle(); wb_rd_wen = 1; wb_rd_addr = 4; wb_data = 32'h44; step("uf");
        idle(); rs1_addr = 4; #1;
        chk("uf.err", {31'b0, sb_err}, 32'h1);
        chk("uf.data", rs1_data, 32'h44);
        step("uf2");
        step("uf3");

        // asynchronous reset mid-cycle clears data, counters and the sticky flag
        idle(); rs1_addr = 5; rs2_addr = 9; #2;
        rst_n = 0; #1;
        m_reset();
        chk("ar.err", {31'b0, sb_err}, 32'h0);
        chk("ar.rs1", rs1_data, 32'h0);
        chk("ar.rs2", rs2_data, 32'h0);
        @(negedge clk);
        rst_n = 1;
        idle(); issue_valid = 1; rs2_addr = 9; rs2_ren = 1; step("ar.nostall");

        // random traffic on a small address window to provoke hazards
        for (int c = 0; c < 600; c++) begin
            idle();
            if (c == 300) begin
                #2; rst_n = 0; #1; m_reset();
                @(negedge clk); rst_n = 1;
            end
            rs1_addr = AW'($urandom_range(0, 7));
            rs2_addr = AW'($urandom_range(0, 7));
            rs1_ren = 1'($urandom);
            rs2_ren = 1'($urandom);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_rd_wen = 1'($urandom);
            issue_rd_addr = AW'($urandom_range(0, 7));
            wb_rd_wen = ($urandom_range(0, 2) != 0);
            pick = $urandom_range(0, 7);
            if ($urandom_range(0, 7) != 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_pend[(pick + k) % 8] > 0) begin
                        pick = (pick + k) % 8;
                        break;
                    end
                end
            end
            wb_rd_addr = AW'(pick);
            wb_data = $urandom;
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
